// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary -> packed BCD converter.
//   Performs one shift per clock. The bcd/overflow outputs are registered and
//   change only when a conversion completes, so a display driver never sees
//   a partially converted value.
// Ports:
//   clk       in   1      system clock, rising edge
//   arst      in   1      asynchronous reset, active-high
//   start     in   1      request conversion of bin (ignored while busy)
//   bin       in   W      unsigned value, sampled on the accepting edge
//   busy      out  1      conversion in progress (SHIFT or DONE)
//   done      out  1      one-cycle pulse: bcd/overflow just updated
//   bcd       out  4*D    packed BCD, bcd[3:0] = ones digit
//   overflow  out  1      last value exceeded 10^D-1 (bcd saturated to 9s)
module bin2bcd_seq #(
  parameter int W = 14,
  parameter int D = 4
) (
  input  logic           clk,
  input  logic           arst,
  input  logic           start,
  input  logic [W-1:0]   bin,
  output logic           busy,
  output logic           done,
  output logic [4*D-1:0] bcd,
  output logic           overflow
);

  // Scratch digits: ceil(W*log10(2)) + 1, computed with integer math
  // (log10(2) ~= 0.30103), never fewer than the presented digits.
  localparam int DS_CALC = (W * 30103 + 99999) / 100000 + 1;
  localparam int DS      = (DS_CALC < D) ? D : DS_CALC;
  localparam int CW      = (W < 1) ? 1 : $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state_q, state_d;
  logic [W-1:0]      shreg_q, shreg_d;
  logic [4*DS-1:0]   scr_q, scr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [4*D-1:0]    bcd_q, bcd_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;

  logic [4*DS-1:0]   adj;
  logic [4*DS+W-1:0] cat;
  logic              hi_nz;

  always_comb begin
    // Add-3 correction on every digit >= 5, applied before the shift.
    adj = scr_q;
    for (int i = 0; i < DS; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
    end
    cat = {adj, shreg_q} << 1;

    // Any non-zero digit beyond the presented ones means overflow.
    hi_nz = 1'b0;
    for (int i = D; i < DS; i++) begin
      if (scr_q[4*i +: 4] != 4'd0) hi_nz = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d = bin;
          scr_d   = '0;
          cnt_d   = CW'(W);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        scr_d   = cat[4*DS+W-1:W];
        shreg_d = cat[W-1:0];
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        ovf_d   = hi_nz;
        bcd_d   = hi_nz ? {D{4'h9}} : scr_q[4*D-1:0];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;
  localparam int W = 14;
  localparam int D = 4;

  logic           clk, arst, start;
  logic [W-1:0]   bin;
  logic           busy, done, overflow;
  logic [4*D-1:0] bcd;

  int n_chk = 0, n_err = 0;
  int done_cnt = 0, bad_chg = 0;
  logic [4*D-1:0] prev_bcd;

  bin2bcd_seq #(.W(W), .D(D)) dut (
    .clk(clk), .arst(arst), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal digits by division, saturating above 10^D-1.
  function automatic logic [4*D:0] ref_conv(input int v);
    logic [4*D-1:0] r;
    int p;
    if (v > 9999) return {1'b1, {D{4'h9}}};
    r = '0;
    p = 1;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return {1'b0, r};
  endfunction

  // bcd must only move on a done cycle (or under reset).
  always @(negedge clk) begin
    if (!arst && bcd !== prev_bcd && !done) bad_chg <= bad_chg + 1;
    if (!arst && done) done_cnt <= done_cnt + 1;
    prev_bcd <= bcd;
  end

  task automatic convert(input int v, input string tag);
    logic [4*D:0] e;
    int n;
    e = ref_conv(v);
    @(negedge clk);
    start = 1'b1;
    bin   = W'(v);
    @(posedge clk);
    #1;
    start = 1'b0;
    bin   = W'($urandom);  // must not affect the running conversion
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (done) break;
    end
    chk({tag, "_lat"}, n, W + 1);
    chk({tag, "_bcd"}, bcd, e[4*D-1:0]);
    chk({tag, "_ovf"}, overflow, e[4*D]);
    @(posedge clk);
    #1;
    chk({tag, "_donelow"}, {busy, done}, 2'b00);
  endtask

  initial begin
    int cur, dc0, last_t, t;
    logic [4*D:0] e;
    arst = 1'b1; start = 1'b0; bin = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", {busy, done, overflow, bcd}, '0);
    @(negedge clk);
    arst = 1'b0;

    // Directed values including boundaries.
    convert(6, "six");
    convert(1234, "v1234");
    convert(9999, "v9999");
    convert(0, "zero");
    convert(16383, "vmax");
    convert(10000, "v10000");
    convert(52, "v52");

    // Start pulses while busy are ignored, including the DONE edge.
    dc0 = done_cnt;
    @(negedge clk);
    start = 1'b1; bin = W'(40);
    for (int ed = 0; ed <= 20; ed++) begin
      if (ed != 0) begin
        @(negedge clk);
        start = (ed == 3 || ed == 15);
        bin   = W'(77);
      end
      @(posedge clk);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("busy_ign_cnt", done_cnt - dc0, 1);
    chk("busy_ign_bcd", bcd, 16'h0040);
    chk("busy_ign_busy", busy, 1'b0);

    // Reset mid-conversion aborts with no done.
    @(negedge clk);
    start = 1'b1; bin = W'(5000);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    arst = 1'b1;
    #1;
    chk("abort_state", {busy, done, overflow, bcd}, '0);
    @(posedge clk);
    #2;
    arst = 1'b0;
    dc0 = done_cnt;
    repeat (25) @(posedge clk);
    #1;
    chk("abort_nodone", done_cnt - dc0, 0);
    chk("abort_bcd", bcd, '0);
    convert(88, "v88");

    // Random values, biased so both ranges are covered.
    for (int k = 0; k < 30; k++) begin
      if (k % 3 == 0) convert(int'($urandom_range(10000, 16383)), "rnd_hi");
      else            convert(int'($urandom_range(0, 9999)), "rnd_lo");
    end

    // start held high: back-to-back conversions along the collatz sequence.
    cur = 6;
    @(negedge clk);
    start = 1'b1; bin = W'(cur);
    last_t = -1;
    t = 0;
    for (int k = 0; k < 8; k++) begin
      int n;
      n = 0;
      for (int i = 0; i < 40; i++) begin
        @(posedge clk);
        #1;
        n++; t++;
        if (done) break;
      end
      chk("clz_found", done, 1'b1);
      if (last_t >= 0) chk("clz_period", t - last_t, W + 2);
      last_t = t;
      e = ref_conv(cur);
      chk("clz_bcd", bcd, e[4*D-1:0]);
      cur = (cur % 2 == 0) ? cur / 2 : 3 * cur + 1;
      bin = W'(cur);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("bcd_stable", bad_chg, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got hang want finish");
    $fatal(1);
  end
endmodule
